// File: rtl/pe_seq_ctrl_if.sv
// Stream and PE-side signal bundle for the PE sequencer.
// master: controller side; slave: sources + PE side.
interface pe_seq_ctrl_if #(
  parameter int L_RAM_SIZE = 3
);
  logic [31:0]           b_tdata;
  logic                  b_tvalid;
  logic                  b_tready;
  logic [31:0]           a_tdata;
  logic                  a_tvalid;
  logic                  a_tready;
  logic [31:0]           pe_din;
  logic [L_RAM_SIZE-1:0] pe_addr;
  logic                  pe_we;
  logic [31:0]           pe_ain;
  logic                  pe_valid;
  logic                  pe_dvalid;
  logic [31:0]           pe_dout;

  modport master (
    input  b_tdata, b_tvalid,
    input  a_tdata, a_tvalid,
    input  pe_dvalid, pe_dout,
    output b_tready, a_tready,
    output pe_din, pe_addr, pe_we,
    output pe_ain, pe_valid
  );

  modport slave (
    output b_tdata, b_tvalid,
    output a_tdata, a_tvalid,
    output pe_dvalid, pe_dout,
    input  b_tready, a_tready,
    input  pe_din, pe_addr, pe_we,
    input  pe_ain, pe_valid
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: loads N weights, streams N activations, latches result.
// Ports: aclk, aresetn, start, bus (pe_seq_ctrl_if.master), busy, done, result.
module pe_seq_ctrl #(
  parameter int L_RAM_SIZE = 3
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  pe_seq_ctrl_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result
);

  localparam int CW = L_RAM_SIZE + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << L_RAM_SIZE) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_CALC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         res_cnt;
  logic [L_RAM_SIZE-1:0] addr_q;

  logic job_go;
  logic hs_b;
  logic hs_a;
  logic dv_en;
  logic dv_last;

  // Handshakes derived from state, not from the ready outputs.
  assign job_go  = (state == S_IDLE) && start;
  assign hs_b    = (state == S_LOAD_B) && bus.b_tvalid;
  assign hs_a    = (state == S_CALC) && bus.a_tvalid;
  assign dv_en   = bus.pe_dvalid &&
                   ((state == S_CALC) || (state == S_DRAIN));
  assign dv_last = dv_en && (state == S_DRAIN) &&
                   (res_cnt == LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (hs_b && (wr_cnt == LAST)) state_nx = S_CALC;
      end
      S_CALC: begin
        if (hs_a && (rd_cnt == LAST)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (dv_last) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.b_tready = 1'b0;
    bus.a_tready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD_B: begin
        bus.b_tready = 1'b1;
        busy         = 1'b1;
      end
      S_CALC: begin
        bus.a_tready = 1'b1;
        busy         = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase

    // Address follows the live handshake, else holds.
    bus.pe_we   = hs_b;
    bus.pe_din  = '0;
    bus.pe_addr = addr_q;
    unique case (1'b1)
      hs_b: begin
        bus.pe_din  = bus.b_tdata;
        bus.pe_addr = wr_cnt[L_RAM_SIZE-1:0];
      end
      hs_a: begin
        bus.pe_addr = rd_cnt[L_RAM_SIZE-1:0];
      end
      default: begin
        bus.pe_addr = addr_q;
      end
    endcase
  end

  // Operand is delayed one cycle to meet the RAM read data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q       <= '0;
      bus.pe_valid <= 1'b0;
      bus.pe_ain   <= '0;
    end else begin
      addr_q       <= bus.pe_addr;
      bus.pe_valid <= hs_a;
      if (hs_a) bus.pe_ain <= bus.a_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      res_cnt <= '0;
    end else if (job_go) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      res_cnt <= '0;
    end else begin
      if (hs_b)  wr_cnt  <= wr_cnt + 1'b1;
      if (hs_a)  rd_cnt  <= rd_cnt + 1'b1;
      if (dv_en) res_cnt <= res_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      result <= '0;
    end else if (dv_last) begin
      result <= bus.pe_dout;
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl with a behavioural PE model.
// Random stalls, start spam, stray dvalid, mid-job reset.
module tb_pe_seq_ctrl;
  localparam int L = 3;
  localparam int N = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  pe_seq_ctrl_if #(.L_RAM_SIZE(L)) bus ();

  pe_seq_ctrl #(.L_RAM_SIZE(L)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (start),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard queues
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] op_a_q[$];
  logic [31:0] op_b_q[$];
  logic [31:0] res_q[$];
  logic [31:0] exp_hold = 0;
  int          done_cnt = 0;
  int          jobs = 0;
  logic        done_prev = 0;

  // Behavioural PE: RAM with 1-cycle read, ideal MAC, delayed result.
  typedef struct {
    int          due;
    logic [31:0] val;
  } pend_t;

  logic [31:0] ram [N];
  logic [31:0] ram_q = 0;
  logic [31:0] acc = 0;
  int          mcnt = 0;
  int          cyc = 0;
  int          lat = 1;
  pend_t       pend[$];
  bit          stray_req = 0;
  int          job_dv = 0;
  int          last_dv_cyc = 0;

  always @(posedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (bus.pe_valid) begin
        acc = acc + bus.pe_ain * ram_q;
        mcnt++;
        pend.push_back('{cyc + lat - 1, acc});
        if (mcnt == N) begin
          acc  = 0;
          mcnt = 0;
        end
      end
      ram_q = ram[bus.pe_addr];
      if (bus.pe_we) ram[bus.pe_addr] = bus.pe_din;
    end
  end

  always @(negedge aclk) begin
    pend_t p;
    bus.pe_dvalid = 1'b0;
    if (stray_req) begin
      bus.pe_dvalid = 1'b1;
      bus.pe_dout   = $urandom;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.pe_dvalid = 1'b1;
      bus.pe_dout   = p.val;
      if (busy) begin
        job_dv++;
        last_dv_cyc = cyc;
      end
    end
  end

  // Monitor
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bus.pe_we) begin
        if (wr_addr_q.size() == 0) fail_now("unexpected_pe_we");
        else begin
          check("wr_addr", 32'(bus.pe_addr), wr_addr_q.pop_front());
          check("wr_data", bus.pe_din, wr_data_q.pop_front());
        end
      end
      if (bus.pe_valid) begin
        if (op_a_q.size() == 0) fail_now("unexpected_pe_valid");
        else begin
          check("op_ain", bus.pe_ain, op_a_q.pop_front());
          check("op_bin", ram_q, op_b_q.pop_front());
        end
      end
      if (done) begin
        check("done_width", 32'(done_prev), 0);
        if (res_q.size() == 0) fail_now("unexpected_done");
        else begin
          exp_hold = res_q.pop_front();
          check("result", result, exp_hold);
          check("done_lag", cyc - last_dv_cyc, 1);
          check("dv_count", job_dv, N);
        end
        job_dv = 0;
        done_cnt++;
      end else begin
        check("result_hold", result, exp_hold);
      end
      done_prev = done;
    end
  end

  task automatic drive_b(input logic [31:0] w [N], input int pct);
    for (int i = 0; i < N; i++) begin
      int  tries = 0;
      bit  hs = 0;
      while (!hs && tries < 400) begin
        @(negedge aclk);
        bus.b_tvalid = ($urandom_range(99) < pct);
        bus.b_tdata  = w[i];
        @(posedge aclk);
        hs = bus.b_tvalid && bus.b_tready;
        tries++;
      end
      if (!hs) begin
        fail_now("b_handshake_timeout");
        break;
      end
    end
    #1 bus.b_tvalid = 1'b0;
  endtask

  task automatic drive_a(input logic [31:0] a [N],
                         input int pct, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int  tries = 0;
      bit  hs = 0;
      while (!hs && tries < 400) begin
        @(negedge aclk);
        bus.a_tvalid = ($urandom_range(99) < pct);
        bus.a_tdata  = a[i];
        @(posedge aclk);
        hs = bus.a_tvalid && bus.a_tready;
        tries++;
      end
      if (!hs) begin
        fail_now("a_handshake_timeout");
        break;
      end
    end
    #1 bus.a_tvalid = 1'b0;
  endtask

  task automatic wait_done(input bit spam);
    int t = 0;
    while (!done && t < 3000) begin
      check("busy_in_job", 32'(busy), 1);
      if (spam) start = ($urandom_range(2) == 0);
      @(negedge aclk);
      t++;
    end
    if (!done) fail_now("done_timeout");
    else if (spam) start = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] w [N],
                          input logic [31:0] a [N],
                          input bit with_res);
    logic [31:0] sum = 0;
    for (int k = 0; k < N; k++) begin
      wr_addr_q.push_back(32'(k));
      wr_data_q.push_back(w[k]);
      op_a_q.push_back(a[k]);
      op_b_q.push_back(w[k]);
      sum = sum + w[k] * a[k];
    end
    if (with_res) res_q.push_back(sum);
  endtask

  // Called at a negedge; returns at the first IDLE negedge after done.
  task automatic run_job(input logic [31:0] w [N],
                         input logic [31:0] a [N],
                         input int pct, input int latency,
                         input bit spam);
    lat = latency;
    push_exp(w, a, 1'b1);
    jobs++;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    fork
      drive_b(w, pct);
      drive_a(a, pct, N);
      wait_done(spam);
    join
    @(negedge aclk);
    start = 1'b0;
    check("busy_idle", 32'(busy), 0);
    check("done_idle", 32'(done), 0);
    check("done_count", done_cnt, jobs);
    check("wr_q_empty", wr_addr_q.size(), 0);
    check("op_q_empty", op_a_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_b_tready"}, 32'(bus.b_tready), 0);
    check({tag, "_a_tready"}, 32'(bus.a_tready), 0);
    check({tag, "_pe_we"},    32'(bus.pe_we), 0);
    check({tag, "_pe_valid"}, 32'(bus.pe_valid), 0);
    check({tag, "_pe_din"},   bus.pe_din, 0);
    check({tag, "_pe_addr"},  32'(bus.pe_addr), 0);
    check({tag, "_pe_ain"},   bus.pe_ain, 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_result"},   result, 0);
  endtask

  task automatic flush_model();
    wr_addr_q.delete();
    wr_data_q.delete();
    op_a_q.delete();
    op_b_q.delete();
    res_q.delete();
    pend.delete();
    acc       = 0;
    mcnt      = 0;
    exp_hold  = 0;
    job_dv    = 0;
    done_prev = 0;
  endtask

  logic [31:0] w [N];
  logic [31:0] a [N];

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.b_tvalid = 1'b0;
    bus.b_tdata  = '0;
    bus.a_tvalid = 1'b0;
    bus.a_tdata  = '0;
    bus.pe_dout  = '0;
    #3;
    check_zero_outputs("reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Weights and activations 1..8, back-to-back
    for (int k = 0; k < N; k++) begin
      w[k] = 32'(k + 1);
      a[k] = 32'(k + 1);
    end
    run_job(w, a, 100, 1, 1'b0);
    check("result_204", result, 204);

    // Same data with ~50% stalls
    run_job(w, a, 50, 4, 1'b0);
    check("result_204_stall", result, 204);

    // Start spammed throughout, long MAC latency
    run_job(w, a, 60, 10, 1'b1);
    check("result_204_spam", result, 204);

    // Stray dvalid while idle must not touch result
    @(posedge aclk);
    #1 stray_req = 1'b1;
    repeat (3) @(posedge aclk);
    #1 stray_req = 1'b0;
    @(negedge aclk);
    check("result_after_stray", result, 204);

    // Two consecutive random jobs, second starts in first IDLE cycle
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) begin
        w[k] = $urandom;
        a[k] = $urandom;
      end
      run_job(w, a, $urandom_range(30, 100),
              $urandom_range(1, 6), 1'b0);
    end

    // Abort mid-CALC after 3 activations
    for (int k = 0; k < N; k++) begin
      w[k] = $urandom;
      a[k] = $urandom;
    end
    lat = 1;
    push_exp(w, a, 1'b0);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    fork
      drive_b(w, 100);
      drive_a(a, 100, 3);
    join
    #1 aresetn = 1'b0;
    #1;
    check_zero_outputs("abort");
    flush_model();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < N; k++) begin
      w[k] = 32'd2;
      a[k] = 32'd3;
    end
    run_job(w, a, 70, 2, 1'b0);
    check("result_48", result, 48);

    // A few more random jobs
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < N; k++) begin
        w[k] = $urandom_range(0, 1000);
        a[k] = $urandom;
      end
      run_job(w, a, $urandom_range(20, 100),
              $urandom_range(1, 10), j[0]);
    end

    repeat (3) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Sequencer for one PE (local RAM plus integer MAC).
- Loads an N-entry weight vector into the PE RAM from a stream, then streams N activation words against it, aligned to the 1-cycle RAM read latency.
- Captures the final MAC result and reports completion to the host/top-level FSM.
- Sits between the AXI-stream-like data sources and the PE instance.

Parameters:
- L_RAM_SIZE, 3, log2 of PE RAM depth; N = 2**L_RAM_SIZE words per vector.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job when in IDLE, ignored otherwise
- b_tdata  in  32  weight word
- b_tvalid  in  1  weight word valid
- b_tready  out  1  controller accepts weight word
- a_tdata  in  32  activation word
- a_tvalid  in  1  activation word valid
- a_tready  out  1  controller accepts activation word
- pe_din  out  32  PE RAM write data
- pe_addr  out  L_RAM_SIZE  PE RAM address
- pe_we  out  1  PE RAM write enable
- pe_ain  out  32  PE port A operand
- pe_valid  out  1  PE MAC operand valid
- pe_dvalid  in  1  PE result valid
- pe_dout  in  32  PE result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the result is captured
- result  out  32  captured final MAC result; holds until the next done

Behaviour:
- Reset (aresetn=0, asynchronous, any state):
  - State goes to IDLE; all counters go to 0.
  - All outputs are 0: b_tready, a_tready, pe_we, pe_valid, pe_din, pe_addr, pe_ain, busy, done, result.
  - A job in progress is abandoned; the PE RAM contents are undefined for the next job.
- States: IDLE, LOAD_B, CALC, DRAIN, DONE.
- IDLE:
  - b_tready=0, a_tready=0.
  - start=1 -> LOAD_B; wr_cnt, rd_cnt and res_cnt cleared.
- LOAD_B:
  - b_tready=1.
  - On each b_tvalid&b_tready: pe_we=1, pe_addr=wr_cnt, pe_din=b_tdata (combinational from the handshake, registered into the PE the same edge), then wr_cnt++.
  - pe_we=0 on cycles without a handshake.
  - After the N-th handshake -> CALC. There is no idle cycle between LOAD_B and CALC.
- CALC:
  - a_tready=1, pe_we=0.
  - On each a_tvalid&a_tready:
    - pe_addr=rd_cnt that cycle.
    - The activation is registered: pe_ain<=a_tdata and pe_valid<=1 on the next cycle, so ain meets bin, which the PE RAM outputs one cycle after the address.
    - rd_cnt++.
  - pe_valid<=0 on cycles following a non-handshake cycle.
  - pe_addr holds its last value when there is no handshake.
  - After the N-th handshake -> DRAIN; a_tready drops the same edge.
- DRAIN:
  - The final pe_valid pulse is issued in the first DRAIN cycle.
  - res_cnt counts pe_dvalid pulses from CALC onward.
  - On the N-th pe_dvalid: result<=pe_dout -> DONE.
  - No timeout: the state waits indefinitely.
- DONE:
  - done=1 for exactly one cycle -> IDLE.
  - start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- pe_dvalid outside CALC/DRAIN is ignored.
- MAC accumulation and clearing are owned by the PE. The controller only counts dvalid pulses and latches the N-th dout.
- No back-pressure toward the PE. Stalls on a_tvalid/b_tvalid insert bubbles: pe_valid=0 or pe_we=0 that cycle.
- Counters are L_RAM_SIZE+1 bits so the value N is representable; pe_addr uses the low L_RAM_SIZE bits.
- Throughput: 1 word/cycle when the stream is valid every cycle. Job latency = N (load) + N (calc) + 1 + MAC latency + 1 (done).

Test Plan:
- N=8, weights 1..8 and activations 1..8 streamed back-to-back with an ideal MAC model -> pe_we high for 8 cycles at addr 0..7; 8 pe_valid pulses with pe_ain k aligned to RAM word k; result=204; done one cycle.
- Randomly deassert b_tvalid/a_tvalid (~50%) with the same data -> identical result 204; pe_we/pe_valid only on handshake-driven cycles; addresses never skip or repeat.
- start pulsed during LOAD_B, CALC and DONE -> ignored; exactly one done per accepted start; busy=1 from the cycle after start through DONE.
- aresetn dropped mid-CALC (after 3 activations) -> all outputs 0 immediately (asynchronous); new job after release with all-2 weights and all-3 activations -> result=48.
- Delay pe_dvalid arbitrarily (MAC latency 1, 4, 10) -> done asserted exactly one cycle after the 8th dvalid; stray pe_dvalid pulses while IDLE do not change result.
- Two consecutive jobs with start in the first IDLE cycle after done -> second result correct; result holds its first value until the second done.
